// File: rtl/alu_ctrl_unit.sv
// -----------------------------------------------------------------------------
// alu_ctrl_unit
//   Registered ALU/MDU control for the ID->EX boundary. Decodes aluop/func into
//   an ALU control code, flags illegal funcs, and sequences multi-cycle
//   mult/div operations with a small IDLE/BUSY/DONE FSM that can stall ID.
//
// Optional feature macro: ALU_CTRL_DIV_EN
//   defined   : div/divu are legal MDU ops with latency DIV_CYCLES
//   undefined : div/divu decode as illegal and never start the MDU
//
// Ports
//   clk         in   1      clock
//   reset       in   1      synchronous, active-high; all outputs go to 0
//   valid_in    in   1      instruction present in ID
//   aluop       in   AOPW   from main decoder (values >= 4 are illegal)
//   func        in   6      instr[5:0]
//   stall_in    in   1      hazard-unit hold; freezes output regs
//   flush       in   1      clears ctrl_valid on the next edge
//   alucontrol  out  CTRLW  registered ALU op
//   ctrl_valid  out  1      registered valid
//   illegal     out  1      registered illegal-func/aluop flag
//   md_start    out  1      1-cycle pulse launching the MDU
//   md_op       out  2      00 mult, 01 multu, 10 div, 11 divu; held while busy
//   hilo_we     out  1      1-cycle pulse, MDU result write to HI/LO
//   stall_out   out  1      combinational stall request to hazard unit
// -----------------------------------------------------------------------------
module alu_ctrl_unit #(
  parameter int AOPW       = 2,
  parameter int CTRLW      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [AOPW-1:0]  aluop,
  input  logic [5:0]       func,
  input  logic             stall_in,
  input  logic             flush,
  output logic [CTRLW-1:0] alucontrol,
  output logic             ctrl_valid,
  output logic             illegal,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             hilo_we,
  output logic             stall_out
);

  // Counter is sized for the longest configured latency; it only ever holds
  // LAT-2, so the wider of the two latencies bounds it.
  localparam int LATMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNTW   = (LATMAX > 2) ? $clog2(LATMAX) : 1;
  localparam logic [CNTW-1:0] MUL_INIT = CNTW'(MUL_CYCLES - 2);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CNTW-1:0] DIV_INIT = CNTW'(DIV_CYCLES - 2);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;

  logic [3:0] ctrl_p0;
  logic       ill_p0;
  logic       md_p0;
  logic [1:0] mdop_p0;
  logic       hilo_rd_p0;
  logic       stall_req;

  // ---- stage p0: combinational decode of the instruction in ID ----
  always_comb begin
    ctrl_p0    = 4'b0000;
    ill_p0     = 1'b0;
    md_p0      = 1'b0;
    mdop_p0    = 2'b00;
    hilo_rd_p0 = 1'b0;
    if (aluop == AOPW'(0)) begin
      ctrl_p0 = 4'b0100;
    end else if (aluop == AOPW'(1)) begin
      ctrl_p0 = 4'b1100;
    end else if (aluop == AOPW'(3)) begin
      ctrl_p0 = 4'b0001;
    end else if (aluop == AOPW'(2)) begin
      case (func)
        6'b100000: ctrl_p0 = 4'b0100;
        6'b100010: ctrl_p0 = 4'b1100;
        6'b100100: ctrl_p0 = 4'b0000;
        6'b100101: ctrl_p0 = 4'b0001;
        6'b100110: ctrl_p0 = 4'b0101;
        6'b100111: ctrl_p0 = 4'b0110;
        6'b101010: ctrl_p0 = 4'b1111;
        6'b101011: ctrl_p0 = 4'b1110;
        6'b000000: ctrl_p0 = 4'b0010;
        6'b000010: ctrl_p0 = 4'b0011;
        6'b010000: begin ctrl_p0 = 4'b1000; hilo_rd_p0 = 1'b1; end
        6'b010010: begin ctrl_p0 = 4'b1001; hilo_rd_p0 = 1'b1; end
        6'b011000: begin md_p0 = 1'b1; mdop_p0 = 2'b00; end
        6'b011001: begin md_p0 = 1'b1; mdop_p0 = 2'b01; end
`ifdef ALU_CTRL_DIV_EN
        6'b011010: begin md_p0 = 1'b1; mdop_p0 = 2'b10; end
        6'b011011: begin md_p0 = 1'b1; mdop_p0 = 2'b11; end
`endif
        default:   ill_p0 = 1'b1;
      endcase
    end else begin
      ill_p0 = 1'b1;
    end
  end

  // A new MDU op, or a HI/LO read, must wait until the MDU is back in IDLE.
  assign stall_req = valid_in & (md_p0 | hilo_rd_p0) & (state != IDLE);
  assign stall_out = stall_req & ~reset;

  // ---- MDU sequencer: next state ----
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_start  = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && valid_in && md_p0 && !stall_in && !flush) begin
          md_start  = 1'b1;
          state_nxt = BUSY;
`ifdef ALU_CTRL_DIV_EN
          cnt_nxt   = mdop_p0[1] ? DIV_INIT : MUL_INIT;
`else
          cnt_nxt   = MUL_INIT;
`endif
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE: begin
        hilo_we   = ~reset;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      md_op <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (md_start) md_op <= mdop_p0;
    end
  end

  // ---- stage p1: registered control toward EX ----
  always_ff @(posedge clk) begin
    if (reset) begin
      alucontrol <= '0;
      ctrl_valid <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      ctrl_valid <= 1'b0;
    end else if (!(stall_in || stall_req)) begin
      alucontrol <= CTRLW'(ctrl_p0);
      ctrl_valid <= valid_in;
      illegal    <= ill_p0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
module tb_alu_ctrl_unit;
  localparam int MULL = 4;
  localparam int DIVL = 32;

  logic       clk = 1'b0;
  logic       reset, valid_in, stall_in, flush;
  logic [1:0] aluop;
  logic [5:0] func;
  logic [3:0] alucontrol;
  logic       ctrl_valid, illegal, md_start, hilo_we, stall_out;
  logic [1:0] md_op;

  alu_ctrl_unit #(.AOPW(2), .CTRLW(4), .MUL_CYCLES(MULL), .DIV_CYCLES(DIVL)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .aluop(aluop), .func(func),
    .stall_in(stall_in), .flush(flush), .alucontrol(alucontrol),
    .ctrl_valid(ctrl_valid), .illegal(illegal), .md_start(md_start),
    .md_op(md_op), .hilo_we(hilo_we), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: registered outputs plus the in-flight MDU op expressed
  // as a start cycle and latency (busy window is (st, st+lat], write at st+lat).
  logic [3:0] m_alu;
  bit         m_vld, m_ill;
  logic [1:0] m_mdop;
  bit         active;
  int         cyc, st, lat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic void ref_decode(input logic [1:0] a, input logic [5:0] f,
                                     output logic [3:0] c, output bit ill,
                                     output bit mdu, output logic [1:0] code,
                                     output bit rdhl);
    c = 4'b0000; ill = 0; mdu = 0; code = 2'b00; rdhl = 0;
    case (a)
      2'd0: c = 4'b0100;
      2'd1: c = 4'b1100;
      2'd3: c = 4'b0001;
      default: begin
        case (f)
          6'b100000: c = 4'b0100;
          6'b100010: c = 4'b1100;
          6'b100100: c = 4'b0000;
          6'b100101: c = 4'b0001;
          6'b100110: c = 4'b0101;
          6'b100111: c = 4'b0110;
          6'b101010: c = 4'b1111;
          6'b101011: c = 4'b1110;
          6'b000000: c = 4'b0010;
          6'b000010: c = 4'b0011;
          6'b010000: begin c = 4'b1000; rdhl = 1; end
          6'b010010: begin c = 4'b1001; rdhl = 1; end
          6'b011000, 6'b011001: begin mdu = 1; code = f[1:0]; end
`ifdef ALU_CTRL_DIV_EN
          6'b011010, 6'b011011: begin mdu = 1; code = f[1:0]; end
`endif
          default: ill = 1;
        endcase
      end
    endcase
  endfunction

  function automatic bit m_busy();
    return active && (cyc > st) && (cyc <= st + lat);
  endfunction

  bit e_start, e_hilo, e_stall;

  task automatic model_comb();
    logic [3:0] c; bit ill, mdu, rdhl; logic [1:0] code;
    ref_decode(aluop, func, c, ill, mdu, code, rdhl);
    e_start = !reset && !m_busy() && valid_in && mdu && !stall_in && !flush;
    e_hilo  = !reset && active && (cyc == st + lat);
    e_stall = !reset && valid_in && (mdu || rdhl) && m_busy();
  endtask

  task automatic compare();
    model_comb();
    chk("alucontrol", alucontrol, m_alu);
    chk("ctrl_valid", ctrl_valid, m_vld);
    chk("illegal",    illegal,    m_ill);
    chk("md_op",      md_op,      m_mdop);
    chk("md_start",   md_start,   e_start);
    chk("hilo_we",    hilo_we,    e_hilo);
    chk("stall_out",  stall_out,  e_stall);
  endtask

  task automatic model_edge();
    logic [3:0] c; bit ill, mdu, rdhl; logic [1:0] code;
    ref_decode(aluop, func, c, ill, mdu, code, rdhl);
    model_comb();
    if (reset) begin
      m_alu = 0; m_vld = 0; m_ill = 0; m_mdop = 0; active = 0;
    end else begin
      if (flush) m_vld = 0;
      else if (!(stall_in || e_stall)) begin
        m_alu = c; m_vld = valid_in; m_ill = ill;
      end
      if (active && cyc == st + lat) active = 0;
      if (e_start) begin
        active = 1; st = cyc; m_mdop = code;
        lat = code[1] ? DIVL : MULL;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [1:0] a, input logic [5:0] f);
    valid_in = v; aluop = a; func = f; stall_in = 0; flush = 0;
  endtask

  logic [5:0] pool [16] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b101010, 6'b101011,
                            6'b000000, 6'b000010, 6'b010000, 6'b010010,
                            6'b011000, 6'b011001, 6'b011010, 6'b011011};

  initial begin
    reset = 1; set_in(0, 2'd0, 6'd0);
    @(posedge clk); #1;
    m_alu = 0; m_vld = 0; m_ill = 0; m_mdop = 0; active = 0; cyc = 0; st = 0; lat = 0;
    tick();
    chk("reset alucontrol", alucontrol, 4'b0000);
    chk("reset ctrl_valid", ctrl_valid, 1'b0);
    chk("reset md_op",      md_op,      2'b00);

    // SUB via R-type
    reset = 0; set_in(1, 2'd2, 6'b100010);
    tick();
    chk("sub alucontrol", alucontrol, 4'b1100);
    chk("sub ctrl_valid", ctrl_valid, 1'b1);
    chk("sub illegal",    illegal,    1'b0);

    // Illegal func
    set_in(1, 2'd2, 6'b111111); #1;
    chk("illegal md_start", md_start, 1'b0);
    tick();
    chk("illegal flag",       illegal,    1'b1);
    chk("illegal alucontrol", alucontrol, 4'b0000);

    // multu: start at t0, write at t4 only, md_op held
    set_in(1, 2'd2, 6'b011001); #1;
    chk("multu md_start t0", md_start, 1'b1);
    tick();
    set_in(1, 2'd0, 6'b000000);
    for (int i = 1; i <= 4; i++) begin
      chk("multu hilo_we", hilo_we, (i == 4) ? 1'b1 : 1'b0);
      chk("multu md_op",   md_op,   2'b01);
      tick();
    end
    chk("multu hilo_we after", hilo_we, 1'b0);

    // mult followed by mfhi: held until the MDU returns to IDLE
    set_in(1, 2'd2, 6'b011000);
    tick();
    set_in(1, 2'd2, 6'b010000); #1;
    chk("mfhi stall t1", stall_out, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("mfhi held alucontrol", alucontrol, 4'b0000);
      tick();
    end
    chk("mfhi stall idle", stall_out, 1'b0);
    tick();
    chk("mfhi loaded", alucontrol, 4'b1000);

    // div
    set_in(1, 2'd2, 6'b011010); #1;
`ifdef ALU_CTRL_DIV_EN
    chk("div md_start", md_start, 1'b1);
    tick();
    set_in(0, 2'd0, 6'd0);
    for (int i = 1; i < 10; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("div reset alucontrol", alucontrol, 4'b0000);
    chk("div reset md_op",      md_op,      2'b00);
    chk("div reset hilo_we",    hilo_we,    1'b0);
    for (int i = 0; i < 40; i++) tick();
`else
    chk("div md_start", md_start, 1'b0);
    tick();
    chk("div illegal", illegal, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("div no write", hilo_we, 1'b0);
`endif

    // Randomized traffic checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) < 1);
      valid_in = ($urandom_range(0, 99) < 80);
      aluop    = ($urandom_range(0, 99) < 60) ? 2'd2 : 2'($urandom_range(0, 3));
      func     = ($urandom_range(0, 99) < 15) ? 6'($urandom) : pool[$urandom_range(0, 15)];
      stall_in = ($urandom_range(0, 99) < 10);
      flush    = ($urandom_range(0, 99) < 5);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
